axis_spi_arbiter: RTL and testbench
===================================

AXIS_SPI_ARBITER -- requirements
Module: axis_spi_arbiter

Interface
REQ-001 Parameter WIDTH, default 8, data width of all AXI4-Stream ports.
REQ-002 clock  input  1  system clock; the block SHALL use one clock, and all state SHALL change on its rising edge.
REQ-003 reset  input  1  reset is synchronous and active-high.
REQ-004 s0_tvalid/s0_tready/s0_tlast  in/out/in  1 each; s0_tdata  input  WIDTH  requester-0 command stream.
REQ-005 s1_tvalid/s1_tready/s1_tlast  in/out/in  1 each; s1_tdata  input  WIDTH  requester-1 command stream.
REQ-006 m0_tvalid/m0_tready/m0_tlast  out/in/out  1 each; m0_tdata  output  WIDTH  requester-0 response stream.
REQ-007 m1_tvalid/m1_tready/m1_tlast  out/in/out  1 each; m1_tdata  output  WIDTH  requester-1 response stream.
REQ-008 x_tvalid/x_tready/x_tlast  out/in/out  1 each; x_tdata  output  WIDTH  command stream into the shared SPI master.
REQ-009 y_tvalid/y_tready/y_tlast  in/out/in  1 each; y_tdata  input  WIDTH  response stream from the shared SPI master.
REQ-010 grant_o  output  2  one-hot owner: 01 = requester 0, 10 = requester 1, 00 = none; drives the external SSEL steering.
REQ-011 busy_o  output  1  high while a transaction owns the master.

Function
REQ-012 The FSM SHALL have three states: IDLE, BUSY and DONE.
REQ-013 In IDLE with any sN_tvalid high, the FSM SHALL register a grant and enter BUSY on the next edge, giving 1 cycle of arbitration latency.
REQ-014 Arbitration SHALL be packet-granular round-robin: on simultaneous requests, grant the requester not granted last; the priority pointer SHALL update only on grant.
REQ-015 In BUSY, the granted sN stream SHALL pass combinationally to x (valid, last, data, with x_tready to sN_tready).
REQ-016 In BUSY, y SHALL pass combinationally to the granted mN stream (with mN_tready to y_tready).
REQ-017 The non-granted sN_tready and mN_tvalid SHALL be 0 at all times.
REQ-018 In IDLE and DONE, x_tvalid, y_tready, all sN_tready and all mN_tvalid SHALL be 0.
REQ-019 The command side SHALL close after the first x handshake with x_tlast=1: the granted sN_tready and x_tvalid are forced to 0 for the remainder of BUSY.
REQ-020 BUSY SHALL exit to DONE on the y handshake with y_tlast=1, and only if the command side is closed; a response tlast seen before the command tlast SHALL not end ownership.
REQ-021 DONE SHALL last exactly 1 cycle, clear grant_o to 00, then return to IDLE; this guarantees SSEL deassertion between packets.
REQ-022 A requester whose tvalid drops mid-packet SHALL keep ownership; no timeout exists.
REQ-023 A zero-beat packet is impossible: the first granted beat SHALL be forwarded even if it carries tlast.
REQ-024 busy_o SHALL be 1 exactly in BUSY and DONE.

Reset
REQ-025 While reset is high, on the next edge: state = IDLE, grant_o = 00, busy_o = 0, command-closed flag = 0, priority pointer favours requester 0.
REQ-026 While reset is high, all valid/ready outputs SHALL be 0.
REQ-027 Reset mid-transaction SHALL abandon the packet without flushing; the upstream stream is responsible for discarding.
REQ-028 The first request after reset SHALL be sampled no earlier than the first cycle with reset low.

Verification
REQ-029 s0 sends 4 bytes A1..A4 (last on A4) and the master echoes 4 bytes -> x carries A1..A4; m0 gets 4 beats with tlast on the 4th; grant_o goes 01, then 00 for 1 cycle; m1_tvalid stays 0.
REQ-030 s0 and s1 assert valid on the same cycle just after reset -> s0 is granted first; s1 is granted 2 cycles after s0's response tlast (DONE, then IDLE arbitration); a subsequent simultaneous request goes to s0 again.
REQ-031 s1 holds valid continuously while s0 issues 3 back-to-back packets -> grants strictly alternate 01, 10, 01.
REQ-032 x_tready or m0_tready stalled for 5 cycles mid-packet -> no beat is lost or duplicated; data order is preserved; grant is held.
REQ-033 Reset asserted during the 2nd byte of a BUSY transaction -> next cycle grant_o = 00, busy_o = 0, all readies are 0; a new s1 request afterwards is granted normally.
REQ-034 Single-beat packet (tlast on the 1st byte) -> a 1-beat command and a 1-beat response; the FSM returns to IDLE.

Source files
------------

// File: rtl/axis_spi_arbiter_if.sv
// AXI4-Stream bundle (valid/ready/last/data) shared by every arbiter port.
interface axis_spi_arbiter_if #(
  parameter int WIDTH = 8
);
  logic             tvalid;
  logic             tready;
  logic             tlast;
  logic [WIDTH-1:0] tdata;

  modport master (output tvalid, output tlast, output tdata, input tready);
  modport slave  (input tvalid, input tlast, input tdata, output tready);
endinterface

// File: rtl/axis_spi_arbiter.sv
// Packet-granular round-robin arbiter giving two AXI4-Stream requesters
// exclusive ownership of one SPI master (command out on x, response in on y).
module axis_spi_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  axis_spi_arbiter_if.slave          s0,
  axis_spi_arbiter_if.slave          s1,
  axis_spi_arbiter_if.master         m0,
  axis_spi_arbiter_if.master         m1,
  axis_spi_arbiter_if.master         x,
  axis_spi_arbiter_if.slave          y,
  output logic [1:0]                 grant_o,
  output logic                       busy_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic [1:0] grant_q, grant_d;
  logic       closed_q, closed_d;
  logic       last_q, last_d;    // 1 when requester 1 held the most recent grant

  logic             active;
  logic             cmd_open;
  logic             pick1;
  logic             x_valid;
  logic             x_last;
  logic [WIDTH-1:0] x_data;
  logic             y_ready;

  // Reset gates the handshakes immediately so an abandoned packet cannot leak a beat.
  assign active   = (state_q == BUSY) && !reset;
  assign cmd_open = active && !closed_q;
  assign pick1    = s1.tvalid && (!s0.tvalid || !last_q);

  always_comb begin
    x_valid = cmd_open && ((grant_q[0] && s0.tvalid) || (grant_q[1] && s1.tvalid));
    x_last  = grant_q[1] ? s1.tlast : s0.tlast;
    x_data  = grant_q[1] ? s1.tdata : s0.tdata;
    y_ready = active && ((grant_q[0] && m0.tready) || (grant_q[1] && m1.tready));
  end

  assign x.tvalid  = x_valid;
  assign x.tlast   = x_last;
  assign x.tdata   = x_data;
  assign s0.tready = cmd_open && grant_q[0] && x.tready;
  assign s1.tready = cmd_open && grant_q[1] && x.tready;

  assign y.tready  = y_ready;
  assign m0.tvalid = active && grant_q[0] && y.tvalid;
  assign m1.tvalid = active && grant_q[1] && y.tvalid;
  assign m0.tlast  = y.tlast;
  assign m1.tlast  = y.tlast;
  assign m0.tdata  = y.tdata;
  assign m1.tdata  = y.tdata;

  assign grant_o = grant_q;
  assign busy_o  = (state_q != IDLE);

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    closed_d = closed_q;
    last_d   = last_q;
    unique case (state_q)
      IDLE: begin
        if (s0.tvalid || s1.tvalid) begin
          grant_d  = pick1 ? 2'b10 : 2'b01;
          last_d   = pick1;
          closed_d = 1'b0;
          state_d  = BUSY;
        end
      end
      BUSY: begin
        if (x_valid && x.tready && x_last) begin
          closed_d = 1'b1;
        end
        // A response tlast only ends ownership once the command packet is complete.
        if (y.tvalid && y_ready && y.tlast && closed_q) begin
          grant_d = 2'b00;
          state_d = DONE;
        end
      end
      DONE: begin
        closed_d = 1'b0;
        state_d  = IDLE;
      end
      default: begin
        grant_d  = 2'b00;
        closed_d = 1'b0;
        state_d  = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      grant_q  <= 2'b00;
      closed_q <= 1'b0;
      last_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      closed_q <= closed_d;
      last_q   <= last_d;
    end
  end

endmodule

// File: tb/tb_axis_spi_arbiter.sv
// Directed bench for axis_spi_arbiter with an echoing SPI-master model on x/y.
module tb_axis_spi_arbiter;

  logic       clock;
  logic       reset;
  logic [1:0] grant_o;
  logic       busy_o;

  axis_spi_arbiter_if #(.WIDTH(8)) s0_if ();
  axis_spi_arbiter_if #(.WIDTH(8)) s1_if ();
  axis_spi_arbiter_if #(.WIDTH(8)) m0_if ();
  axis_spi_arbiter_if #(.WIDTH(8)) m1_if ();
  axis_spi_arbiter_if #(.WIDTH(8)) x_if ();
  axis_spi_arbiter_if #(.WIDTH(8)) y_if ();

  axis_spi_arbiter #(.WIDTH(8)) dut (
    .clock   (clock),
    .reset   (reset),
    .s0      (s0_if),
    .s1      (s1_if),
    .m0      (m0_if),
    .m1      (m1_if),
    .x       (x_if),
    .y       (y_if),
    .grant_o (grant_o),
    .busy_o  (busy_o)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic [7:0] d;
    logic       l;
  } beat_t;

  int         n_chk = 0;
  int         n_err = 0;
  logic [7:0] x_log[$];
  logic [7:0] m0_log[$];
  logic [7:0] m1_log[$];
  logic [1:0] grant_log[$];
  beat_t      resp_q[$];
  int         m0_pkts, m1_pkts, m0_last_at;
  bit         m1_vseen;
  logic [1:0] prev_grant = 2'b00;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] qat(input logic [7:0] q[$], input int i);
    if (i < q.size()) return q[i];
    return 8'hxx;
  endfunction

  function automatic logic [1:0] gl(input int i);
    if (i < grant_log.size()) return grant_log[i];
    return 2'bxx;
  endfunction

  task automatic clear_logs();
    x_log.delete();
    m0_log.delete();
    m1_log.delete();
    grant_log.delete();
    m0_pkts    = 0;
    m1_pkts    = 0;
    m0_last_at = 0;
    m1_vseen   = 0;
  endtask

  task automatic drive_s(input int p, input logic v, input logic [7:0] d, input logic l);
    if (p == 0) begin
      s0_if.tvalid = v; s0_if.tdata = d; s0_if.tlast = l;
    end else begin
      s1_if.tvalid = v; s1_if.tdata = d; s1_if.tlast = l;
    end
  endtask

  // Presents n beats base, base+1, ... on requester p, tlast on the final beat.
  task automatic send_s(input int p, input int n, input logic [7:0] base);
    for (int i = 0; i < n; i++) begin
      bit hs;
      int cyc;
      hs  = 0;
      cyc = 0;
      drive_s(p, 1'b1, 8'(base + i), (i == n - 1));
      while (!hs && cyc < 200) begin
        @(negedge clock);
        hs = (p == 0) ? s0_if.tready : s1_if.tready;
        @(posedge clock); #1;
        cyc++;
      end
      chk($sformatf("s%0d_handshake", p), 32'(hs), 1);
    end
    drive_s(p, 1'b0, 8'h00, 1'b0);
  endtask

  // Returns at posedge+1 of the cycle in which response packet number 'target' completed.
  task automatic wait_m(input int p, input int target);
    int cyc;
    cyc = 0;
    while (((p == 0) ? m0_pkts : m1_pkts) < target && cyc < 300) begin
      @(posedge clock); #1;
      cyc++;
    end
    chk($sformatf("m%0d_resp_done", p), 32'(((p == 0) ? m0_pkts : m1_pkts) >= target), 1);
  endtask

  // Monitor: logs accepted beats and feeds the echo queue of the SPI-master model.
  initial begin
    forever begin
      @(posedge clock);
      if (!reset) begin
        if (x_if.tvalid && x_if.tready) begin
          x_log.push_back(x_if.tdata);
          resp_q.push_back('{d: x_if.tdata, l: x_if.tlast});
        end
        if (m0_if.tvalid && m0_if.tready) begin
          m0_log.push_back(m0_if.tdata);
          if (m0_if.tlast) begin
            m0_pkts++;
            m0_last_at = m0_log.size();
          end
        end
        if (m1_if.tvalid && m1_if.tready) begin
          m1_log.push_back(m1_if.tdata);
          if (m1_if.tlast) m1_pkts++;
        end
        if (m1_if.tvalid) m1_vseen = 1;
        if (grant_o != prev_grant && grant_o != 2'b00) grant_log.push_back(grant_o);
      end
      prev_grant = grant_o;
    end
  end

  // SPI-master model: echoes every accepted command beat back on y.
  initial begin
    y_if.tvalid = 1'b0;
    y_if.tlast  = 1'b0;
    y_if.tdata  = 8'h00;
    forever begin
      @(posedge clock); #1;
      if (resp_q.size() > 0) begin
        y_if.tvalid = 1'b1;
        y_if.tdata  = resp_q[0].d;
        y_if.tlast  = resp_q[0].l;
      end else begin
        y_if.tvalid = 1'b0;
        y_if.tlast  = 1'b0;
      end
      @(negedge clock);
      if (y_if.tvalid && y_if.tready && resp_q.size() > 0) void'(resp_q.pop_front());
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    drive_s(0, 1'b0, 8'h00, 1'b0);
    drive_s(1, 1'b0, 8'h00, 1'b0);
    x_if.tready  = 1'b1;
    m0_if.tready = 1'b1;
    m1_if.tready = 1'b1;
    clear_logs();
    repeat (3) @(posedge clock);
    #1;
    chk("rst_grant",  32'(grant_o), 0);
    chk("rst_busy",   32'(busy_o), 0);
    chk("rst_xvalid", 32'(x_if.tvalid), 0);
    chk("rst_yready", 32'(y_if.tready), 0);
    chk("rst_s0rdy",  32'(s0_if.tready), 0);
    chk("rst_m0vld",  32'(m0_if.tvalid), 0);
    reset = 1'b0;

    // Simultaneous requests just after reset: s0 first, s1 after DONE + IDLE.
    clear_logs();
    fork
      send_s(0, 2, 8'h10);
      send_s(1, 2, 8'h20);
    join_none
    wait_m(0, 1);
    chk("sim_done_grant", 32'(grant_o), 0);
    chk("sim_done_busy",  32'(busy_o), 1);
    @(posedge clock); #1;
    chk("sim_idle_busy",  32'(busy_o), 0);
    chk("sim_idle_grant", 32'(grant_o), 0);
    @(posedge clock); #1;
    chk("sim_s1_grant",   32'(grant_o), 2);
    wait_m(1, 1);
    wait fork;
    chk("sim_first_grant", 32'(gl(0)), 1);
    chk("sim_m0_b0", 32'(qat(m0_log, 0)), 'h10);
    chk("sim_m0_b1", 32'(qat(m0_log, 1)), 'h11);
    chk("sim_m1_b0", 32'(qat(m1_log, 0)), 'h20);
    chk("sim_m1_b1", 32'(qat(m1_log, 1)), 'h21);

    // Next simultaneous request goes back to s0.
    clear_logs();
    fork
      send_s(0, 1, 8'h30);
      send_s(1, 1, 8'h40);
    join
    wait_m(0, 1);
    wait_m(1, 1);
    chk("sim2_grant0", 32'(gl(0)), 1);
    chk("sim2_grant1", 32'(gl(1)), 2);

    // Basic 4-byte transfer on s0.
    clear_logs();
    send_s(0, 4, 8'hA1);
    wait_m(0, 1);
    chk("t4_done_grant", 32'(grant_o), 0);
    chk("t4_done_busy",  32'(busy_o), 1);
    @(posedge clock); #1;
    chk("t4_idle_busy",  32'(busy_o), 0);
    chk("t4_xcount",  32'(x_log.size()), 4);
    chk("t4_m0count", 32'(m0_log.size()), 4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t4_x%0d", i),  32'(qat(x_log, i)),  32'(8'hA1 + i));
      chk($sformatf("t4_m0%0d", i), 32'(qat(m0_log, i)), 32'(8'hA1 + i));
    end
    chk("t4_m0_last_at", 32'(m0_last_at), 4);
    chk("t4_grant",      32'(gl(0)), 1);
    chk("t4_m1_quiet",   32'(m1_vseen), 0);

    // s1 continuously requesting while s0 issues three packets back to back.
    clear_logs();
    fork
      begin
        repeat (3) send_s(0, 2, 8'h60);
      end
      begin
        @(posedge clock); #1;
        send_s(1, 2, 8'h70);
        send_s(1, 2, 8'h78);
      end
    join
    wait_m(0, 3);
    wait_m(1, 2);
    chk("rr_count", 32'(grant_log.size()), 5);
    chk("rr_g0", 32'(gl(0)), 1);
    chk("rr_g1", 32'(gl(1)), 2);
    chk("rr_g2", 32'(gl(2)), 1);
    chk("rr_g3", 32'(gl(3)), 2);
    chk("rr_g4", 32'(gl(4)), 1);

    // x_tready then m0_tready stalled for 5 cycles mid-packet.
    clear_logs();
    fork
      send_s(0, 4, 8'hC1);
      begin
        repeat (3) @(posedge clock);
        #1;
        x_if.tready = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        chk("stall_x_grant", 32'(grant_o), 1);
        chk("stall_x_s0rdy", 32'(s0_if.tready), 0);
        repeat (2) @(posedge clock);
        #1;
        x_if.tready = 1'b1;
      end
    join
    begin
      int c;
      c = 0;
      while (m0_log.size() < 1 && c < 100) begin
        @(posedge clock); #1;
        c++;
      end
      chk("stall_m_started", 32'(m0_log.size() >= 1), 1);
    end
    m0_if.tready = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("stall_m_grant", 32'(grant_o), 1);
    chk("stall_m_yrdy",  32'(y_if.tready), 0);
    repeat (2) @(posedge clock);
    #1;
    m0_if.tready = 1'b1;
    wait_m(0, 1);
    chk("stall_xcount",  32'(x_log.size()), 4);
    chk("stall_m0count", 32'(m0_log.size()), 4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("stall_x%0d", i),  32'(qat(x_log, i)),  32'(8'hC1 + i));
      chk($sformatf("stall_m0%0d", i), 32'(qat(m0_log, i)), 32'(8'hC1 + i));
    end

    // Single-beat packet.
    clear_logs();
    send_s(0, 1, 8'h5A);
    wait_m(0, 1);
    chk("one_done_busy", 32'(busy_o), 1);
    chk("one_xcount",    32'(x_log.size()), 1);
    chk("one_x0",        32'(qat(x_log, 0)), 'h5A);
    chk("one_m0count",   32'(m0_log.size()), 1);
    chk("one_m0",        32'(qat(m0_log, 0)), 'h5A);
    @(posedge clock); #1;
    chk("one_idle_busy", 32'(busy_o), 0);

    // Reset asserted while the 2nd byte of an s0 packet is on offer.
    clear_logs();
    drive_s(0, 1'b1, 8'hD1, 1'b0);
    @(posedge clock); #1;
    chk("rmid_grant", 32'(grant_o), 1);
    @(posedge clock); #1;
    drive_s(0, 1'b1, 8'hD2, 1'b0);
    chk("rmid_s0rdy_byte2", 32'(s0_if.tready), 1);
    reset = 1'b1;
    drive_s(0, 1'b0, 8'h00, 1'b0);
    @(posedge clock); #1;
    chk("rmid_grant_after", 32'(grant_o), 0);
    chk("rmid_busy_after",  32'(busy_o), 0);
    chk("rmid_s0rdy",       32'(s0_if.tready), 0);
    chk("rmid_s1rdy",       32'(s1_if.tready), 0);
    chk("rmid_yrdy",        32'(y_if.tready), 0);
    reset = 1'b0;
    resp_q.delete();
    repeat (2) @(posedge clock);
    #1;
    chk("rmid_idle_m0vld", 32'(m0_if.tvalid), 0);
    chk("rmid_idle_xvld",  32'(x_if.tvalid), 0);
    clear_logs();
    send_s(1, 2, 8'hE1);
    wait_m(1, 1);
    chk("rmid_s1_grant", 32'(gl(0)), 2);
    chk("rmid_m1_b0",    32'(qat(m1_log, 0)), 'hE1);
    chk("rmid_m1_b1",    32'(qat(m1_log, 1)), 'hE2);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
